pm_fir_filter: RTL and testbench
================================

Name: pm_fir_filter

Overview:
Parametrised FIR filter with three power modes: full-rate RUN, decimated low-power LP, and power-gated OFF with state retention. Sits between the sample source and downstream DSP. It is the next generation of the team's low-power filter block, adding:
- run-time loadable coefficients
- fixed-point scaling with saturation
- valid handshakes
- a sequenced save/isolate/restore power-gating FSM with acknowledge

Parameters:
DATA_W, 16, sample and output width (signed)
COEF_W, 16, coefficient width (signed)
TAPS, 4, number of taps (>=2)
FRAC_BITS, 12, coefficient fractional bits; 1.0 = 1<<FRAC_BITS
LP_DIV, 8, in LP, one of every LP_DIV valid samples is processed (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  data_in holds a sample this cycle
data_in  in  DATA_W  signed input sample
lp_mode  in  1  1 = LP decimated mode, 0 = RUN
pg_req  in  1  level request to power-gate the datapath
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  coefficient index
coef_wdata  in  COEF_W  coefficient value
out_valid  out  1  one-cycle pulse, data_out updated
data_out  out  DATA_W  signed filtered output; clamped to 0 while iso_en
iso_en  out  1  isolation active
pg_ack  out  1  datapath is off; retention holds state
pwr_state  out  3  encoded FSM state

Behaviour:
- Reset (async): all outputs 0, FSM=RUN, delay line 0, retention 0, LP counter 0, coef[0]=1<<FRAC_BITS, other coefs 0.
- FSM states: RUN=0, LP=1, SAVE=2, OFF=3, RESTORE=4.
- RUN/LP select: state follows lp_mode each cycle while pg_req=0. Any RUN<->LP transition clears the LP counter.
- Accept rule: a sample is accepted when the state is RUN or LP, in_valid=1 and pg_req=0. In LP, acceptance additionally requires LP counter == LP_DIV-1.
- LP counter: increments on every in_valid in LP and wraps to 0 on an accepted sample. Non-accepted samples are dropped.
- Accepted sample x[n]: the delay line shifts, and y[n] = sum_{k=0..TAPS-1} c[k]*x[n-k] is computed with x[n] in tap 0.
- Latency: data_out and out_valid update at the clock edge following acceptance, so latency is 1 cycle. data_out holds its value between pulses.
- Arithmetic:
  - products are DATA_W+COEF_W bits; accumulation is full precision (ACC_W = DATA_W+COEF_W+clog2(TAPS));
  - the accumulator is arithmetic-shifted right by FRAC_BITS (truncation toward -inf);
  - the result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Power-down: pg_req=1 in RUN or LP -> SAVE. The in_valid sample in that cycle is dropped.
- SAVE (1 cycle): iso_en=1, delay line copied to retention -> OFF.
- OFF:
  - pg_ack=1, iso_en=1, out_valid=0, data_out=0;
  - delay line forced to 0 to model state loss; inputs ignored;
  - pg_req=0 -> RESTORE.
- RESTORE (1 cycle): pg_ack=0, iso_en=1, retention copied to delay line. Next state is LP if lp_mode=1, else RUN; iso_en drops on entry to that state.
- Output across power-down: the data_out register keeps its last value internally and reappears when iso_en drops.
- pg_req deasserted during SAVE: the FSM still completes SAVE->OFF->RESTORE (no abort).
- Coefficient writes: accepted in every state, including OFF (always-on domain), and take effect on the next accepted sample. A write in the same cycle as an accepted sample uses the old value.
- Reset mid-operation (any state, including OFF): immediate return to reset values. Retention is also cleared.

Decomposition:
- Package pm_fir_pkg: state enum, ACC_W function, saturate function, COEF_ONE constant.
- One sub-module, pm_fir_mac: combinational TAPS-wide multiply-accumulate with shift and saturate. The parent owns the FSM, delay line, retention and coefficient registers.

Test Plan:
- Impulse, defaults FRAC_BITS=12: coefs 0x1000,0x0800,0x0400,0x0000; samples 100,0,0,0,0 -> data_out 100,50,25,0,0, each 1 cycle after acceptance.
- Saturation: coef[0]=0x4000, others 0; inputs 0x7000 then -0x7000 -> data_out 0x7FFF, then 0x8000.
- LP: lp_mode=1, LP_DIV=8, 16 consecutive valid samples 1..16 with coef[0]=1.0 -> exactly two out_valid pulses, data_out 8 then 16.
- Power-gate round trip:
  - stimulus: load 10,20,30 with identity coefs, then pg_req 1 for 10 cycles with in_valid toggling, then pg_req 0, then sample 40 with coefs 1.0 all taps;
  - required: states SAVE->OFF->RESTORE->RUN; pg_ack high only in OFF; data_out=0 while iso_en; final output 100.
- Reset during OFF: pg_ack=0, iso_en=0, state RUN, and the first post-reset sample 5 with default coefs -> data_out 5 (no residual history).
- Coefficient write in the same cycle as an accepted sample: the output uses the old coefficient; the next sample uses the new one.

Source files
------------

// File: rtl/pm_fir_pkg.sv
// Shared types and arithmetic helpers for the power-managed FIR filter.
// Pure declarations: no latency, no flow control.
package pm_fir_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LP      = 3'd1,
    ST_SAVE    = 3'd2,
    ST_OFF     = 3'd3,
    ST_RESTORE = 3'd4
  } pwr_state_t;

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Fixed-point 1.0; the caller narrows this to COEF_W bits.
  function automatic longint coef_one(input int frac_bits);
    return longint'(1) <<< frac_bits;
  endfunction

  // Clamp v to the signed range of a w-bit value.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pm_fir_mac.sv
// Combinational TAPS-wide multiply-accumulate, arithmetic shift and saturate; 0 cycles.
// No flow control: the parent samples y only when it accepts a sample.
module pm_fir_mac
  import pm_fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 4,
  parameter int FRAC_BITS = 12
) (
  input  logic [TAPS*DATA_W-1:0] taps,
  input  logic [TAPS*COEF_W-1:0] coefs,
  output logic [DATA_W-1:0]      y
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] x;
  logic signed [COEF_W-1:0] c;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;

  always_comb begin
    x    = '0;
    c    = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < TAPS; k++) begin
      x    = taps[k*DATA_W +: DATA_W];
      c    = coefs[k*COEF_W +: COEF_W];
      prod = x * c;
      acc  = acc + ACC_W'(prod);
    end
    // >>> on a signed accumulator truncates toward -inf.
    shifted = acc >>> FRAC_BITS;
    y       = DATA_W'(saturate(64'(shifted), DATA_W));
  end

endmodule

// File: rtl/pm_fir_filter.sv
// FIR filter with RUN / decimated LP / power-gated OFF modes and state retention; 1-cycle latency.
// No backpressure: samples arriving while gated, gating, or between LP decimation slots are dropped.
module pm_fir_filter
  import pm_fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 4,
  parameter int FRAC_BITS = 12,
  parameter int LP_DIV    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     lp_mode,
  input  logic                     pg_req,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        data_out,
  output logic                     iso_en,
  output logic                     pg_ack,
  output logic [2:0]               pwr_state
);

  localparam int                CNT_W    = $clog2(LP_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LP_DIV - 1);
  localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(coef_one(FRAC_BITS));

  pwr_state_t state, state_nxt;

  logic [DATA_W-1:0] dl   [TAPS];
  logic [DATA_W-1:0] ret  [TAPS];
  logic [COEF_W-1:0] coef [TAPS];

  logic [CNT_W-1:0]       lp_cnt;
  logic                   run_or_lp;
  logic                   accept;
  logic                   out_valid_q;
  logic [DATA_W-1:0]      data_q;
  logic [DATA_W-1:0]      mac_y;
  logic [TAPS*DATA_W-1:0] taps_flat;
  logic [TAPS*COEF_W-1:0] coef_flat;

  assign run_or_lp = (state == ST_RUN) || (state == ST_LP);
  assign accept    = run_or_lp && in_valid && !pg_req &&
                     ((state == ST_RUN) || (lp_cnt == CNT_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN, ST_LP: begin
        if (pg_req)       state_nxt = ST_SAVE;
        else if (lp_mode) state_nxt = ST_LP;
        else              state_nxt = ST_RUN;
      end
      ST_SAVE:    state_nxt = ST_OFF;
      ST_OFF:     state_nxt = pg_req ? ST_OFF : ST_RESTORE;
      ST_RESTORE: state_nxt = lp_mode ? ST_LP : ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // A RUN<->LP switch restarts the decimation phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lp_cnt <= '0;
    end else if (run_or_lp && !pg_req && (state_nxt != state)) begin
      lp_cnt <= '0;
    end else if ((state == ST_LP) && in_valid && !pg_req) begin
      lp_cnt <= accept ? '0 : lp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        dl[k]  <= '0;
        ret[k] <= '0;
      end
    end else begin
      case (state)
        ST_SAVE: for (int k = 0; k < TAPS; k++) ret[k] <= dl[k];
        ST_OFF:  for (int k = 0; k < TAPS; k++) dl[k]  <= '0;
        ST_RESTORE: for (int k = 0; k < TAPS; k++) dl[k] <= ret[k];
        default: begin
          if (accept) begin
            dl[0] <= data_in;
            for (int k = 1; k < TAPS; k++) dl[k] <= dl[k-1];
          end
        end
      endcase
    end
  end

  // Coefficients live in the always-on domain and accept writes in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? COEF_ONE : '0;
    end else if (coef_we && (int'(coef_addr) < TAPS)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  always_comb begin
    taps_flat = '0;
    coef_flat = '0;
    taps_flat[DATA_W-1:0] = data_in;
    for (int k = 1; k < TAPS; k++) taps_flat[k*DATA_W +: DATA_W] = dl[k-1];
    for (int k = 0; k < TAPS; k++) coef_flat[k*COEF_W +: COEF_W] = coef[k];
  end

  pm_fir_mac #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .taps (taps_flat),
    .coefs(coef_flat),
    .y    (mac_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      out_valid_q <= accept;
      if (accept) data_q <= mac_y;
    end
  end

  assign iso_en    = (state == ST_SAVE) || (state == ST_OFF) || (state == ST_RESTORE);
  assign pg_ack    = (state == ST_OFF);
  assign pwr_state = state;
  assign out_valid = out_valid_q && !iso_en;
  assign data_out  = iso_en ? '0 : data_q;

endmodule

// File: tb/tb_pm_fir_filter.sv
// Directed-vector bench for pm_fir_filter at default parameters.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_pm_fir_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] data_in;
  logic        lp_mode;
  logic        pg_req;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        out_valid;
  logic [15:0] data_out;
  logic        iso_en;
  logic        pg_ack;
  logic [2:0]  pwr_state;

  int errors = 0;
  int checks = 0;

  pm_fir_filter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .lp_mode   (lp_mode),
    .pg_req    (pg_req),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .out_valid (out_valid),
    .data_out  (data_out),
    .iso_en    (iso_en),
    .pg_ack    (pg_ack),
    .pwr_state (pwr_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; data_in = '0; lp_mode = 1'b0; pg_req = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [15:0] v);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    in_valid = 1'b1; data_in = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, data_out, iso_en, pg_ack, pwr_state} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state ov=%b do=%h iso=%b ack=%b st=%0d expected all 0",
               out_valid, data_out, iso_en, pg_ack, pwr_state);
    end
  endtask

  task automatic test_impulse();
    logic [15:0] samp [5] = '{16'd100, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] expv [5] = '{16'd100, 16'd50, 16'd25, 16'd0, 16'd0};
    do_reset();
    write_coef(0, 16'h1000); write_coef(1, 16'h0800);
    write_coef(2, 16'h0400); write_coef(3, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; data_in = samp[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || data_out !== expv[i]) begin
        errors++;
        $display("FAIL impulse[%0d] ov=%b do=%0d expected ov=1 do=%0d", i, out_valid, data_out, expv[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'd0) begin
      errors++;
      $display("FAIL impulse_hold ov=%b do=%0d expected ov=0 do=0", out_valid, data_out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    write_coef(0, 16'h4000);
    send(16'h7000);
    checks++;
    if (data_out !== 16'h7FFF) begin
      errors++; $display("FAIL sat_pos do=%h expected 7fff", data_out);
    end
    send(16'h9000);
    checks++;
    if (data_out !== 16'h8000) begin
      errors++; $display("FAIL sat_neg do=%h expected 8000", data_out);
    end
  endtask

  task automatic test_lp();
    int pulses = 0;
    do_reset();
    lp_mode = 1'b1;
    tick();
    checks++;
    if (pwr_state !== 3'd1) begin
      errors++; $display("FAIL lp_enter st=%0d expected 1", pwr_state);
    end
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; data_in = 16'(i + 1);
      tick();
      if (out_valid === 1'b1) pulses++;
      checks++;
      if (out_valid !== (i == 7 || i == 15)) begin
        errors++; $display("FAIL lp_pulse[%0d] ov=%b expected %b", i, out_valid, (i == 7 || i == 15));
      end
      if (i == 7 || i == 15) begin
        checks++;
        if (data_out !== 16'(i + 1)) begin
          errors++; $display("FAIL lp_data[%0d] do=%0d expected %0d", i, data_out, i + 1);
        end
      end
    end
    in_valid = 1'b0; lp_mode = 1'b0;
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL lp_count pulses=%0d expected 2", pulses);
    end
  endtask

  task automatic test_power_gate();
    do_reset();
    send(16'd10); send(16'd20); send(16'd30);
    checks++;
    if (data_out !== 16'd30) begin
      errors++; $display("FAIL pg_preload do=%0d expected 30", data_out);
    end
    for (int i = 0; i < 10; i++) begin
      pg_req = 1'b1; in_valid = i[0]; data_in = 16'd999;
      tick();
      checks++;
      if (pwr_state !== ((i == 0) ? 3'd2 : 3'd3) || pg_ack !== (i != 0) || iso_en !== 1'b1 ||
          data_out !== 16'd0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pg_down[%0d] st=%0d ack=%b iso=%b do=%0d ov=%b expected st=%0d ack=%b iso=1 do=0 ov=0",
                 i, pwr_state, pg_ack, iso_en, data_out, out_valid, (i == 0) ? 2 : 3, (i != 0));
      end
    end
    pg_req = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (pwr_state !== 3'd4 || pg_ack !== 1'b0 || iso_en !== 1'b1 || data_out !== 16'd0) begin
      errors++;
      $display("FAIL pg_restore st=%0d ack=%b iso=%b do=%0d expected st=4 ack=0 iso=1 do=0",
               pwr_state, pg_ack, iso_en, data_out);
    end
    tick();
    checks++;
    if (pwr_state !== 3'd0 || iso_en !== 1'b0 || data_out !== 16'd30) begin
      errors++;
      $display("FAIL pg_resume st=%0d iso=%b do=%0d expected st=0 iso=0 do=30", pwr_state, iso_en, data_out);
    end
    for (int k = 0; k < 4; k++) write_coef(2'(k), 16'h1000);
    send(16'd40);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'd100) begin
      errors++; $display("FAIL pg_history ov=%b do=%0d expected ov=1 do=100", out_valid, data_out);
    end
  endtask

  task automatic test_reset_in_off();
    do_reset();
    for (int k = 0; k < 4; k++) write_coef(2'(k), 16'h1000);
    send(16'd7); send(16'd8);
    pg_req = 1'b1;
    tick(); tick();
    checks++;
    if (pg_ack !== 1'b1) begin
      errors++; $display("FAIL rst_off_reach ack=%b expected 1", pg_ack);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pg_ack !== 1'b0 || iso_en !== 1'b0 || pwr_state !== 3'd0) begin
      errors++;
      $display("FAIL rst_off_async ack=%b iso=%b st=%0d expected ack=0 iso=0 st=0", pg_ack, iso_en, pwr_state);
    end
    pg_req = 1'b0;
    tick();
    reset = 1'b0;
    send(16'd5);
    checks++;
    if (data_out !== 16'd5) begin
      errors++; $display("FAIL rst_off_first do=%0d expected 5", data_out);
    end
    for (int k = 0; k < 4; k++) write_coef(2'(k), 16'h1000);
    send(16'd6);
    checks++;
    if (data_out !== 16'd11) begin
      errors++; $display("FAIL rst_off_history do=%0d expected 11", data_out);
    end
  endtask

  task automatic test_coef_same_cycle();
    do_reset();
    in_valid = 1'b1; data_in = 16'd10;
    coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 16'h2000;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    checks++;
    if (data_out !== 16'd10) begin
      errors++; $display("FAIL coef_old do=%0d expected 10", data_out);
    end
    send(16'd10);
    checks++;
    if (data_out !== 16'd20) begin
      errors++; $display("FAIL coef_new do=%0d expected 20", data_out);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_lp();
    test_power_gate();
    test_reset_in_off();
    test_coef_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
